// File: rtl/symbol_stream_feeder_if.sv
// -----------------------------------------------------------------------------
// symbol_stream_feeder_if
// Bundles the buffer write port, the stream control inputs and the output
// beat handshake of symbol_stream_feeder.
//   master : sequence loader / consumer side (drives writes, control, ready)
//   slave  : the feeder itself (drives beats, busy, done)
// Signals:
//   wr_en/wr_addr/wr_data : word write into the symbol buffer
//   start/stop/loop_mode  : stream control
//   sym_len               : number of symbols per pass
//   out_valid/out_ready   : beat handshake
//   out_sym/out_mask      : beat payload, lane 0 in the low bits
//   busy/done             : streaming status, end-of-pass pulse
// -----------------------------------------------------------------------------
interface symbol_stream_feeder_if #(
  parameter int SYM_W  = 2,
  parameter int LANES  = 1,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 128,
  parameter int LEN_W  = $clog2(DEPTH * WORD_W / SYM_W) + 1
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [WORD_W-1:0]        wr_data;
  logic                     start;
  logic                     stop;
  logic                     loop_mode;
  logic [LEN_W-1:0]         sym_len;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*SYM_W-1:0]   out_sym;
  logic [LANES-1:0]         out_mask;
  logic                     busy;
  logic                     done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_mode, sym_len, out_ready,
    input  out_valid, out_sym, out_mask, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_mode, sym_len, out_ready,
    output out_valid, out_sym, out_mask, busy, done
  );
endinterface

// File: rtl/symbol_stream_feeder.sv
// -----------------------------------------------------------------------------
// symbol_stream_feeder
// Holds a packed symbol sequence in a word buffer and streams it LSB-first,
// LANES symbols per beat, over a valid/ready handshake. Supports programmable
// length (clamped to buffer capacity), partial last beat with lane mask, loop
// mode, abort and a one-cycle done pulse per pass.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset (buffer contents are kept)
//   io_bus : symbol_stream_feeder_if.slave (write port, control, beat stream)
// -----------------------------------------------------------------------------
module symbol_stream_feeder #(
  parameter int SYM_W  = 2,
  parameter int LANES  = 1,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 128,
  parameter int LEN_W  = $clog2(DEPTH * WORD_W / SYM_W) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  symbol_stream_feeder_if.slave   io_bus
);
  localparam int SPW = WORD_W / SYM_W;   // symbols per buffer word
  localparam int CAP = DEPTH * SPW;      // buffer capacity in symbols
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW  = LANES * SYM_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [WORD_W-1:0] r_mem [DEPTH];

  state_t           r_state;
  logic [LEN_W-1:0] r_ptr;
  logic [LEN_W-1:0] r_len;
  logic             r_loop;
  logic             r_out_valid;
  logic [BW-1:0]    r_out_sym;
  logic [LANES-1:0] r_out_mask;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_ptr_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic             w_loop_nxt;
  logic             w_valid_nxt;
  logic             w_done_nxt;
  logic [LEN_W-1:0] w_len_clamped;
  logic             w_hs;
  logic             w_last;
  logic [AW-1:0]    w_word_idx;
  logic [LEN_W-1:0] w_sym_ofs;
  logic [WORD_W-1:0] w_word;
  logic [BW-1:0]    w_beat_sym;
  logic [LANES-1:0] w_beat_mask;

  assign w_len_clamped = (io_bus.sym_len > LEN_W'(CAP)) ? LEN_W'(CAP) : io_bus.sym_len;
  assign w_hs          = r_out_valid & io_bus.out_ready;
  // Final beat of a pass: the beat reaches or passes the programmed length.
  assign w_last        = ({1'b0, r_ptr} + (LEN_W+1)'(LANES)) >= {1'b0, r_len};

  // Buffer write port; accepted only while idle and deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (io_bus.wr_en && (r_state == ST_IDLE)) begin
      r_mem[io_bus.wr_addr] <= io_bus.wr_data;
    end
  end

  // Next-state, pointer and output-strobe decode for the IDLE/RUN machine.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_len_nxt   = r_len;
    w_loop_nxt  = r_loop;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_len_nxt  = w_len_clamped;
          w_loop_nxt = io_bus.loop_mode;
          w_ptr_nxt  = LEN_W'(0);
          if (w_len_clamped != LEN_W'(0)) begin
            w_state_nxt = ST_RUN;
            w_valid_nxt = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        // stop wins over a simultaneous handshake; the pending beat is dropped
        if (io_bus.stop) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = LEN_W'(0);
        end else if (w_hs) begin
          if (w_last) begin
            w_done_nxt = 1'b1;
            w_ptr_nxt  = LEN_W'(0);
            if (r_loop) begin
              w_state_nxt = ST_RUN;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_ptr_nxt   = r_ptr + LEN_W'(LANES);
            w_valid_nxt = 1'b1;
          end
        end else begin
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = LEN_W'(0);
      end
    endcase
  end

  // Beat assembly for the next pointer. A beat never straddles a word because
  // WORD_W is a multiple of SYM_W*LANES and the pointer advances by LANES.
  always_comb begin
    w_word_idx  = AW'(w_ptr_nxt / LEN_W'(SPW));
    w_sym_ofs   = w_ptr_nxt % LEN_W'(SPW);
    w_word      = r_mem[w_word_idx];
    w_beat_sym  = BW'(0);
    w_beat_mask = LANES'(0);
    for (int i = 0; i < LANES; i++) begin
      if (w_valid_nxt && (({1'b0, w_ptr_nxt} + (LEN_W+1)'(i)) < {1'b0, w_len_nxt})) begin
        w_beat_sym  = w_beat_sym |
                      (BW'(SYM_W'(w_word >> ((int'(w_sym_ofs) + i) * SYM_W))) << (i * SYM_W));
        w_beat_mask = w_beat_mask | (LANES'(1) << i);
      end else begin
        w_beat_sym  = w_beat_sym;
        w_beat_mask = w_beat_mask;
      end
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= LEN_W'(0);
      r_len       <= LEN_W'(0);
      r_loop      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sym   <= BW'(0);
      r_out_mask  <= LANES'(0);
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_len       <= w_len_nxt;
      r_loop      <= w_loop_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_sym   <= w_beat_sym;
      r_out_mask  <= w_beat_mask;
      r_busy      <= (w_state_nxt == ST_RUN);
      r_done      <= w_done_nxt;
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_sym   = r_out_sym;
  assign io_bus.out_mask  = r_out_mask;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;

endmodule

// File: tb/tb_symbol_stream_feeder.sv
module tb_symbol_stream_feeder;
  localparam int LEN_W = 12;

  typedef struct packed {
    logic [7:0] sym;
    logic [3:0] mask;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [128];
  beat_t q1[$];
  beat_t q4[$];

  symbol_stream_feeder_if #(.LANES(1)) b1 ();
  symbol_stream_feeder_if #(.LANES(4)) b4 ();

  symbol_stream_feeder #(.LANES(1)) dut1 (.i_clk(clk), .i_rst(rst), .io_bus(b1.slave));
  symbol_stream_feeder #(.LANES(4)) dut4 (.i_clk(clk), .i_rst(rst), .io_bus(b4.slave));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_sym(int k);
    logic [31:0] w;
    w = model_mem[k / 16];
    return 2'(w >> (2 * (k % 16)));
  endfunction

  function automatic void push_pass1(int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b = '0;
      b.sym = 8'(exp_sym(k));
      b.mask = 4'b0001;
      q1.push_back(b);
    end
  endfunction

  function automatic void push_pass4(int len);
    beat_t b;
    for (int p = 0; p < len; p += 4) begin
      b = '0;
      for (int i = 0; i < 4; i++) begin
        if (p + i < len) begin
          b.sym = b.sym | (8'(exp_sym(p + i)) << (2 * i));
          b.mask = b.mask | (4'b0001 << i);
        end
      end
      q4.push_back(b);
    end
  endfunction

  task automatic write_word(int addr, logic [31:0] data);
    b1.wr_en = 1'b1; b1.wr_addr = 7'(addr); b1.wr_data = data;
    b4.wr_en = 1'b1; b4.wr_addr = 7'(addr); b4.wr_data = data;
    model_mem[addr] = data;
    cyc();
    b1.wr_en = 1'b0;
    b4.wr_en = 1'b0;
  endtask

  task automatic start1(int len, logic lp);
    b1.sym_len = LEN_W'(len); b1.loop_mode = lp; b1.start = 1'b1;
    cyc();
    b1.start = 1'b0;
  endtask

  task automatic start4(int len, logic lp);
    b4.sym_len = LEN_W'(len); b4.loop_mode = lp; b4.start = 1'b1;
    cyc();
    b4.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    checks++;
    if ({b1.out_valid, b1.busy, b1.done, b1.out_mask} !== 4'b0000 || b1.out_sym !== 2'b00) begin
      errors++; $display("FAIL reset_dut1: got v/b/d/m=%b sym=%h, want 0000 sym=0",
                         {b1.out_valid, b1.busy, b1.done, b1.out_mask}, b1.out_sym);
    end
    checks++;
    if ({b4.out_valid, b4.busy, b4.done} !== 3'b000 || b4.out_mask !== 4'h0 || b4.out_sym !== 8'h00) begin
      errors++; $display("FAIL reset_dut4: got v/b/d=%b mask=%h sym=%h, want all 0",
                         {b4.out_valid, b4.busy, b4.done}, b4.out_mask, b4.out_sym);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if ({b1.out_valid, b1.busy, b1.done} !== 3'b000) begin
      errors++; $display("FAIL reset_release: got v/b/d=%b, want 000", {b1.out_valid, b1.busy, b1.done});
    end
  endtask

  task automatic test_basic();
    int got; logic last_prev; logic last_now; beat_t e;
    q1.delete(); push_pass1(8);
    b1.out_ready = 1'b1;
    start1(8, 1'b0);
    got = 0; last_prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (b1.done !== last_prev) begin
        errors++; $display("FAIL basic_done c=%0d: got %b, want %b", c, b1.done, last_prev);
      end
      checks++;
      if (b1.out_valid !== 1'(got < 8) || b1.busy !== 1'(got < 8)) begin
        errors++; $display("FAIL basic_valid c=%0d: got v=%b busy=%b, want %b", c, b1.out_valid, b1.busy, 1'(got < 8));
      end
      last_now = 1'b0;
      if (b1.out_valid && b1.out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL basic_extra: got beat sym=%h, want none", b1.out_sym);
        end else begin
          e = q1.pop_front();
          if (b1.out_sym !== e.sym[1:0] || b1.out_mask !== e.mask[0]) begin
            errors++; $display("FAIL basic_beat %0d: got sym=%h mask=%b, want sym=%h mask=%b",
                               got, b1.out_sym, b1.out_mask, e.sym[1:0], e.mask[0]);
          end
        end
        got++;
        last_now = 1'(got == 8);
      end
      last_prev = last_now;
      cyc();
    end
    checks++;
    if (got != 8 || q1.size() != 0) begin
      errors++; $display("FAIL basic_count: got %0d beats, want 8", got);
    end
  endtask

  task automatic test_lanes4();
    int got; logic last_prev; logic last_now; beat_t e;
    q4.delete(); push_pass4(6);
    b4.out_ready = 1'b1;
    start4(6, 1'b0);
    got = 0; last_prev = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (b4.done !== last_prev || b4.out_valid !== 1'(got < 2)) begin
        errors++; $display("FAIL lanes4_ctrl c=%0d: got done=%b v=%b, want done=%b v=%b",
                           c, b4.done, b4.out_valid, last_prev, 1'(got < 2));
      end
      last_now = 1'b0;
      if (b4.out_valid && b4.out_ready) begin
        checks++;
        if (q4.size() == 0) begin
          errors++; $display("FAIL lanes4_extra: got sym=%h, want none", b4.out_sym);
        end else begin
          e = q4.pop_front();
          if (b4.out_sym !== e.sym || b4.out_mask !== e.mask) begin
            errors++; $display("FAIL lanes4_beat %0d: got sym=%h mask=%h, want sym=%h mask=%h",
                               got, b4.out_sym, b4.out_mask, e.sym, e.mask);
          end
        end
        got++;
        last_now = 1'(got == 2);
      end
      last_prev = last_now;
      cyc();
    end
    checks++;
    if (got != 2 || q4.size() != 0) begin
      errors++; $display("FAIL lanes4_count: got %0d beats, want 2", got);
    end
  endtask

  task automatic test_backpressure();
    int got; logic last_prev; logic last_now; logic stalled; beat_t e;
    logic [1:0] held_sym; logic held_mask;
    logic [3:0] pat;
    pat = 4'b1001;
    q1.delete(); push_pass1(20);
    b1.out_ready = 1'b0;
    start1(20, 1'b0);
    got = 0; last_prev = 1'b0; stalled = 1'b0; held_sym = 2'b00; held_mask = 1'b0;
    for (int c = 0; c < 60; c++) begin
      b1.out_ready = pat[2'(c)];
      if (stalled) begin
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_sym !== held_sym || b1.out_mask !== held_mask) begin
          errors++; $display("FAIL bp_hold c=%0d: got v=%b sym=%h, want v=1 sym=%h", c, b1.out_valid, b1.out_sym, held_sym);
        end
      end
      checks++;
      if (b1.done !== last_prev || b1.out_valid !== 1'(got < 20)) begin
        errors++; $display("FAIL bp_ctrl c=%0d: got done=%b v=%b, want done=%b v=%b",
                           c, b1.done, b1.out_valid, last_prev, 1'(got < 20));
      end
      last_now = 1'b0;
      if (b1.out_valid && b1.out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL bp_extra: got sym=%h, want none", b1.out_sym);
        end else begin
          e = q1.pop_front();
          if (b1.out_sym !== e.sym[1:0]) begin
            errors++; $display("FAIL bp_beat %0d: got sym=%h, want %h", got, b1.out_sym, e.sym[1:0]);
          end
        end
        got++;
        last_now = 1'(got == 20);
      end
      stalled = b1.out_valid & ~b1.out_ready;
      held_sym = b1.out_sym; held_mask = b1.out_mask;
      last_prev = last_now;
      cyc();
    end
    checks++;
    if (got != 20 || q1.size() != 0) begin
      errors++; $display("FAIL bp_count: got %0d beats, want 20", got);
    end
    b1.out_ready = 1'b1;
  endtask

  task automatic test_loop();
    int got; logic last_prev; logic last_now; logic stopped; beat_t e;
    q1.delete(); push_pass1(3); push_pass1(1);
    b1.out_ready = 1'b1;
    start1(3, 1'b1);
    got = 0; last_prev = 1'b0; stopped = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (b1.done !== last_prev) begin
        errors++; $display("FAIL loop_done c=%0d: got %b, want %b", c, b1.done, last_prev);
      end
      if (got == 4) begin
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_sym !== exp_sym(1)) begin
          errors++; $display("FAIL loop_beat5: got v=%b sym=%h, want v=1 sym=%h", b1.out_valid, b1.out_sym, exp_sym(1));
        end
        b1.stop = 1'b1;
        cyc();
        b1.stop = 1'b0;
        checks++;
        if ({b1.out_valid, b1.busy, b1.done} !== 3'b000) begin
          errors++; $display("FAIL loop_stop: got v/b/d=%b, want 000", {b1.out_valid, b1.busy, b1.done});
        end
        cyc();
        checks++;
        if ({b1.out_valid, b1.done} !== 2'b00) begin
          errors++; $display("FAIL loop_after_stop: got v/d=%b, want 00", {b1.out_valid, b1.done});
        end
        stopped = 1'b1;
        break;
      end
      checks++;
      if (b1.out_valid !== 1'b1) begin
        errors++; $display("FAIL loop_gap c=%0d: got v=%b, want 1", c, b1.out_valid);
      end
      last_now = 1'b0;
      if (b1.out_valid && b1.out_ready) begin
        checks++;
        e = q1.pop_front();
        if (b1.out_sym !== e.sym[1:0]) begin
          errors++; $display("FAIL loop_sym %0d: got %h, want %h", got, b1.out_sym, e.sym[1:0]);
        end
        got++;
        last_now = 1'(got % 3 == 0);
      end
      last_prev = last_now;
      cyc();
    end
    checks++;
    if (stopped !== 1'b1) begin
      errors++; $display("FAIL loop_timeout: got %0d beats, want stop at beat 5", got);
    end
  endtask

  task automatic test_zero_len();
    start1(0, 1'b0);
    checks++;
    if ({b1.done, b1.out_valid, b1.busy} !== 3'b100) begin
      errors++; $display("FAIL zero_done: got d/v/b=%b, want 100", {b1.done, b1.out_valid, b1.busy});
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++;
      if ({b1.done, b1.out_valid, b1.busy} !== 3'b000) begin
        errors++; $display("FAIL zero_after c=%0d: got d/v/b=%b, want 000", c, {b1.done, b1.out_valid, b1.busy});
      end
    end
  endtask

  task automatic test_ignore_in_run();
    int got; beat_t e;
    q1.delete(); push_pass1(8);
    b1.out_ready = 1'b1;
    start1(8, 1'b0);
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin
        b1.start = 1'b1; b1.sym_len = LEN_W'(2);
        b1.wr_en = 1'b1; b1.wr_addr = 7'd0; b1.wr_data = 32'h0000_0000;
      end else begin
        b1.start = 1'b0; b1.wr_en = 1'b0;
      end
      if (b1.out_valid && b1.out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL run_ignore_extra: got sym=%h, want none", b1.out_sym);
        end else begin
          e = q1.pop_front();
          if (b1.out_sym !== e.sym[1:0]) begin
            errors++; $display("FAIL run_ignore_sym %0d: got %h, want %h", got, b1.out_sym, e.sym[1:0]);
          end
        end
        got++;
      end
      cyc();
    end
    checks++;
    if (got != 8 || b1.busy !== 1'b0) begin
      errors++; $display("FAIL run_ignore_count: got %0d beats busy=%b, want 8 busy=0", got, b1.busy);
    end
  endtask

  task automatic test_reset_mid();
    int got; beat_t e;
    q1.delete(); push_pass1(8);
    b1.out_ready = 1'b1;
    start1(8, 1'b0);
    got = 0;
    for (int c = 0; c < 3; c++) begin
      if (b1.out_valid && b1.out_ready) begin
        checks++;
        e = q1.pop_front();
        if (b1.out_sym !== e.sym[1:0]) begin
          errors++; $display("FAIL rstmid_sym %0d: got %h, want %h", got, b1.out_sym, e.sym[1:0]);
        end
        got++;
      end
      cyc();
    end
    rst = 1'b1;
    cyc();
    checks++;
    if ({b1.out_valid, b1.busy, b1.done, b1.out_mask} !== 4'b0000 || b1.out_sym !== 2'b00) begin
      errors++; $display("FAIL rstmid_outputs: got v/b/d/m=%b sym=%h, want 0000 sym=0",
                         {b1.out_valid, b1.busy, b1.done, b1.out_mask}, b1.out_sym);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if ({b1.out_valid, b1.done} !== 2'b00) begin
      errors++; $display("FAIL rstmid_release: got v/d=%b, want 00", {b1.out_valid, b1.done});
    end
    test_basic();
  endtask

  initial begin
    b1.wr_en = 1'b0; b1.wr_addr = 7'd0; b1.wr_data = 32'h0; b1.start = 1'b0; b1.stop = 1'b0;
    b1.loop_mode = 1'b0; b1.sym_len = LEN_W'(0); b1.out_ready = 1'b0;
    b4.wr_en = 1'b0; b4.wr_addr = 7'd0; b4.wr_data = 32'h0; b4.start = 1'b0; b4.stop = 1'b0;
    b4.loop_mode = 1'b0; b4.sym_len = LEN_W'(0); b4.out_ready = 1'b0;

    test_reset();
    write_word(0, 32'hE4E4_E4E4);
    write_word(1, 32'h5AF0_0F5A);
    test_basic();
    test_lanes4();
    test_backpressure();
    test_loop();
    test_zero_len();
    test_ignore_in_run();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
